sdr_engine_arbiter: RTL and testbench
=====================================

// Module: sdr_engine_arbiter
// PURPOSE
//  Shares the single SDR tx/rx engine (SCL/SDA datapath) between the controller sub-blocks: CRH, DAA, private
//  transfers and CCC issue. Grants one requester at a time and enables the engine for it. Holds the grant until
//  the engine reports done, then enforces a bus-free gap. Sits between the requester FSMs and the SDR engine in
//  the controller top.
// PARAMETERS
//  N_REQ         4    number of requesters; index 0 = CRH, fixed highest priority; 1..N_REQ-1 round-robin
//  BUS_FREE_CYC  4    idle cycles in RELEASE after each transfer, minimum 1
//  TIMEOUT_CYC   4095 watchdog limit in BUSY, cycles; used only with SDR_ARB_TIMEOUT_EN
//  ID_W          2    $clog2(N_REQ)
// PORTS
//  i_sdr_clk        in   1      system clock
//  i_sdr_rst_n      in   1      asynchronous active-low reset
//  i_arb_req        in   N_REQ  level requests, held by requester until its o_arb_done pulse
//  i_arb_bus_idle   in   1      bus monitor reports SCL/SDA idle
//  i_sdr_ctrl_done  in   1      single-cycle pulse from SDR engine: transfer finished
//  o_arb_gnt        out  N_REQ  one-hot grant, registered
//  o_arb_gnt_id     out  ID_W   binary index of granted requester, valid while o_arb_busy
//  o_arb_busy       out  1      high in GRANT and BUSY
//  o_sdr_en         out  1      engine enable, high in GRANT and BUSY
//  o_arb_done       out  N_REQ  one-cycle pulse to the owning requester at release
//  o_arb_timeout    out  1      one-cycle pulse on watchdog abort; SDR_ARB_TIMEOUT_EN only
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. RR pointer = 1. Gap counter and watchdog = 0. Reset asserted mid-transfer
//   drops the grant and o_sdr_en immediately and asynchronously. No o_arb_done is issued.
//  States: IDLE -> GRANT -> BUSY -> RELEASE -> IDLE.
//  IDLE: if |i_arb_req && i_arb_bus_idle, pick a winner. Req[0] wins if set; otherwise take the first set bit at
//   or after the RR pointer, wrapping N_REQ-1 -> 1. Next edge: o_arb_gnt/o_arb_gnt_id/o_sdr_en/o_arb_busy go high
//   and state moves to GRANT. This is 1-cycle latency. If i_arb_bus_idle=0, hold IDLE with no grant.
//  GRANT: lasts exactly one cycle, so the engine samples o_sdr_en. Then BUSY.
//  BUSY: hold the grant regardless of i_arb_req. A deasserted request is ignored and the engine completes. On
//   i_sdr_ctrl_done, next edge: o_arb_gnt=0, o_sdr_en=0, o_arb_busy=0, o_arb_done[id]=1 for one cycle, state
//   RELEASE. A done pulse arriving in GRANT is treated identically, so zero-length transfers are legal. Done in
//   IDLE/RELEASE is ignored.
//  RR pointer: after each grant to id>=1, pointer = id+1, wrapping to 1. Grants to id 0 do not move it.
//  RELEASE: count BUS_FREE_CYC cycles, then IDLE. Requests arriving in RELEASE are not granted early. The
//   earliest next grant is BUS_FREE_CYC+1 cycles after o_arb_done.
//  Simultaneous: a new req[0] in the same cycle as done is served after RELEASE. Multiple reqs are resolved only
//   in IDLE.
//  o_arb_gnt is always one-hot or zero. It is never asserted outside GRANT/BUSY.
// CONFIGURATION
//  SDR_ARB_TIMEOUT_EN defined:
//   - A watchdog counts cycles in BUSY, saturating at TIMEOUT_CYC.
//   - On reaching TIMEOUT_CYC without done, next edge: o_arb_timeout=1 for one cycle. o_arb_done[id]=1 in the
//     same cycle and the grant drops, then RELEASE.
//   - The watchdog clears on leaving BUSY.
//  SDR_ARB_TIMEOUT_EN undefined:
//   - No watchdog logic. o_arb_timeout is tied 0 and BUSY waits indefinitely.
// STRUCTURE
//  Package sdr_arb_pkg: state encoding (IDLE/GRANT/BUSY/RELEASE localparams), requester index constants
//   (REQ_CRH=0, REQ_DAA=1, REQ_PRIV=2, REQ_CCC=3), default BUS_FREE_CYC/TIMEOUT_CYC.
//  Sub-module arb_rr_picker (combinational): inputs req vector and pointer; outputs one-hot winner, binary id
//   and a valid flag. Implements fixed priority for bit 0 and rotating priority for the rest.
//  Top holds the FSM, RR pointer register, gap counter and optional watchdog.
// TESTING
//  1. Reset, bus_idle=1, req=4'b0010 -> gnt=0010 and id=1 next cycle. o_sdr_en stays high until done pulse.
//     o_arb_done=0010 for 1 cycle after done.
//  2. req=4'b1110 held, three transfers -> grant order 1,2,3, then 1 (wrap skips 0). Each new grant comes
//     BUS_FREE_CYC+1 cycles after the previous done.
//  3. req=4'b0110 in IDLE plus req[0] raised during BUSY of id 1 -> after RELEASE, id 0 granted before id 2.
//  4. bus_idle=0 with req=0001 -> no grant. bus_idle rises -> gnt=0001 next cycle.
//  5. Reset pulse mid-BUSY -> gnt/o_sdr_en/busy=0 at once, no done pulse. After reset req=1000 -> id 3 granted
//     (pointer back at 1, ids 1-2 idle).
//  6. With SDR_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, no done -> o_arb_timeout and o_arb_done pulse 17 cycles after
//     grant, grant drops. Without the macro -> grant held at 1000 cycles.

Source files
------------

// File: rtl/sdr_engine_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sdr_arb_pkg
// Shared definitions for the SDR engine arbiter:
//   - arb_state_e : FSM state encoding (IDLE/GRANT/BUSY/RELEASE)
//   - REQ_*       : requester slot indices (CRH is slot 0, fixed priority)
//   - DEF_*       : default gap and watchdog lengths
// ---------------------------------------------------------------------------
package sdr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int REQ_CRH  = 0;
    localparam int REQ_DAA  = 1;
    localparam int REQ_PRIV = 2;
    localparam int REQ_CCC  = 3;

    localparam int DEF_BUS_FREE_CYC = 4;
    localparam int DEF_TIMEOUT_CYC  = 4095;

endpackage : sdr_arb_pkg

// File: rtl/sdr_engine_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdr_engine_arbiter_if
// Groups the arbiter's request/grant/engine handshake signals.
//   i_arb_req       requester -> arbiter  level requests, one bit per requester
//   i_arb_bus_idle  monitor   -> arbiter  SCL/SDA idle
//   i_sdr_ctrl_done engine    -> arbiter  one-cycle transfer-finished pulse
//   o_arb_gnt       arbiter   -> requester one-hot grant
//   o_arb_gnt_id    arbiter   -> engine   binary index of the owner
//   o_arb_busy      arbiter   -> all      high while a grant is held
//   o_sdr_en        arbiter   -> engine   engine enable
//   o_arb_done      arbiter   -> requester one-cycle release pulse
//   o_arb_timeout   arbiter   -> all      one-cycle watchdog abort pulse
// Modports: master = requesters/engine side, slave = arbiter.
// ---------------------------------------------------------------------------
interface sdr_engine_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);

    logic [N_REQ-1:0] i_arb_req;
    logic             i_arb_bus_idle;
    logic             i_sdr_ctrl_done;
    logic [N_REQ-1:0] o_arb_gnt;
    logic [ID_W-1:0]  o_arb_gnt_id;
    logic             o_arb_busy;
    logic             o_sdr_en;
    logic [N_REQ-1:0] o_arb_done;
    logic             o_arb_timeout;

    modport master (
        output i_arb_req, i_arb_bus_idle, i_sdr_ctrl_done,
        input  o_arb_gnt, o_arb_gnt_id, o_arb_busy, o_sdr_en, o_arb_done, o_arb_timeout
    );

    modport slave (
        input  i_arb_req, i_arb_bus_idle, i_sdr_ctrl_done,
        output o_arb_gnt, o_arb_gnt_id, o_arb_busy, o_sdr_en, o_arb_done, o_arb_timeout
    );

endinterface : sdr_engine_arbiter_if

// File: rtl/sdr_engine_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// arb_rr_picker
// Combinational winner selection. Slot 0 (CRH) always wins when requesting;
// otherwise the first requesting slot at or after ptr wins, scanning
// ptr .. N_REQ-1 then wrapping to 1 (slot 0 is never part of the rotation).
// Ports:
//   req        in   N_REQ  request vector
//   ptr        in   ID_W   round-robin start slot (1..N_REQ-1)
//   gnt_onehot out  N_REQ  one-hot winner (zero when no request)
//   gnt_id     out  ID_W   binary index of the winner
//   valid      out  1      any request present
// N_REQ must be at least 2.
// ---------------------------------------------------------------------------
module arb_rr_picker
    import sdr_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_id,
    output logic             valid
);

    localparam logic [ID_W-1:0] CRH_ID = ID_W'(REQ_CRH);

    // A zero pointer cannot occur in normal operation; treat it as slot 1 so
    // the rotation arithmetic below never goes negative.
    int base;
    assign base = (ptr == '0) ? 1 : int'(ptr);

    // cand_id[k] is the slot examined k-th in rotating order.
    logic [ID_W-1:0] cand_id [0:N_REQ-2];

    for (genvar gi = 0; gi < N_REQ - 1; gi++) begin : g_cand
        assign cand_id[gi] = ID_W'(((base - 1 + gi) % (N_REQ - 1)) + 1);
    end

    logic found;

    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        found      = 1'b0;
        valid      = |req;
        if (req[CRH_ID]) begin
            gnt_onehot[CRH_ID] = 1'b1;
            gnt_id             = CRH_ID;
        end else begin
            for (int k = 0; k < N_REQ - 1; k++) begin
                if (!found && req[cand_id[k]]) begin
                    found                  = 1'b1;
                    gnt_onehot[cand_id[k]] = 1'b1;
                    gnt_id                 = cand_id[k];
                end
            end
        end
    end

endmodule : arb_rr_picker

// File: rtl/sdr_engine_arbiter.sv
// ---------------------------------------------------------------------------
// sdr_engine_arbiter
// Shares the single SDR tx/rx engine between CRH, DAA, private-transfer and
// CCC requesters. One grant at a time, held until the engine's done pulse,
// followed by a BUS_FREE_CYC-cycle bus-free gap before the next arbitration.
// Ports:
//   i_sdr_clk    in   system clock
//   i_sdr_rst_n  in   asynchronous active-low reset
//   arb          slave modport of sdr_engine_arbiter_if (req/grant/engine)
// Optional feature: define SDR_ARB_TIMEOUT_EN to add a BUSY watchdog that
// aborts a transfer after TIMEOUT_CYC cycles (o_arb_timeout + o_arb_done).
// Without it o_arb_timeout is tied low and BUSY waits indefinitely.
// ---------------------------------------------------------------------------
module sdr_engine_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BUS_FREE_CYC = DEF_BUS_FREE_CYC,
`ifdef SDR_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
`endif
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                 i_sdr_clk,
    input  logic                 i_sdr_rst_n,
    sdr_engine_arbiter_if.slave  arb
);

    localparam int                GAP_W    = $clog2(BUS_FREE_CYC + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(BUS_FREE_CYC - 1);
    localparam logic [ID_W-1:0]   RR_FIRST = ID_W'(REQ_DAA);
    localparam logic [ID_W-1:0]   RR_LAST  = ID_W'(N_REQ - 1);

    arb_state_e        state_reg,  state_next;
    logic [N_REQ-1:0]  gnt_reg,    gnt_next;
    logic [ID_W-1:0]   gnt_id_reg, gnt_id_next;
    logic              busy_reg,   busy_next;
    logic [N_REQ-1:0]  done_reg,   done_next;
    logic [ID_W-1:0]   ptr_reg,    ptr_next;
    logic [GAP_W-1:0]  gap_reg,    gap_next;

    logic [N_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic              xfer_end;

    arb_rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req        (arb.i_arb_req),
        .ptr        (ptr_reg),
        .gnt_onehot (pick_onehot),
        .gnt_id     (pick_id),
        .valid      (pick_valid)
    );

`ifdef SDR_ARB_TIMEOUT_EN
    localparam int               WDOG_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    logic [WDOG_W-1:0] wdog_reg;
    logic              timeout_reg;
    logic              wdog_expire;

    // Fires on the last permitted BUSY cycle so the abort registers exactly
    // TIMEOUT_CYC BUSY cycles after entry. A done arriving in that same
    // cycle wins and is reported as a normal completion.
    assign wdog_expire = (state_reg == ST_BUSY) && (wdog_reg == WDOG_LAST);
    assign xfer_end    = arb.i_sdr_ctrl_done | wdog_expire;

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            wdog_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= wdog_expire & ~arb.i_sdr_ctrl_done;
            if (state_reg != ST_BUSY) begin
                wdog_reg <= '0;
            end else if (wdog_reg != WDOG_MAX) begin
                wdog_reg <= wdog_reg + WDOG_W'(1);
            end
        end
    end

    assign arb.o_arb_timeout = timeout_reg;
`else
    assign xfer_end          = arb.i_sdr_ctrl_done;
    assign arb.o_arb_timeout = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        gnt_id_next = gnt_id_reg;
        busy_next   = busy_reg;
        done_next   = '0;
        ptr_next    = ptr_reg;
        gap_next    = gap_reg;

        case (state_reg)
            ST_IDLE: begin
                if (pick_valid && arb.i_arb_bus_idle) begin
                    gnt_next    = pick_onehot;
                    gnt_id_next = pick_id;
                    busy_next   = 1'b1;
                    state_next  = ST_GRANT;
                    // CRH grants leave the rotation untouched.
                    if (pick_id != '0) begin
                        ptr_next = (pick_id == RR_LAST) ? RR_FIRST : pick_id + ID_W'(1);
                    end
                end
            end
            ST_GRANT, ST_BUSY: begin
                if (xfer_end) begin
                    done_next   = gnt_reg;
                    gnt_next    = '0;
                    gnt_id_next = '0;
                    busy_next   = 1'b0;
                    gap_next    = '0;
                    state_next  = ST_RELEASE;
                end else begin
                    state_next  = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                if (gap_reg == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    gap_next   = gap_reg + GAP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_sdr_clk or negedge i_sdr_rst_n) begin
        if (!i_sdr_rst_n) begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= '0;
            ptr_reg    <= RR_FIRST;
            gap_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            gnt_id_reg <= gnt_id_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            ptr_reg    <= ptr_next;
            gap_reg    <= gap_next;
        end
    end

    // Engine enable and busy flag are the same registered condition.
    assign arb.o_arb_gnt    = gnt_reg;
    assign arb.o_arb_gnt_id = gnt_id_reg;
    assign arb.o_arb_busy   = busy_reg;
    assign arb.o_sdr_en     = busy_reg;
    assign arb.o_arb_done   = done_reg;

endmodule : sdr_engine_arbiter

// File: tb/tb_sdr_engine_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdr_engine_arbiter
// Directed stimulus with hand-computed expectations for the SDR engine
// arbiter (N_REQ=4, BUS_FREE_CYC=4, so grant-to-grant gap after done is 5).
// ---------------------------------------------------------------------------
module tb_sdr_engine_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sdr_engine_arbiter_if #(.N_REQ(4), .ID_W(2)) arb_if ();

    sdr_engine_arbiter #(
        .N_REQ        (4),
        .BUS_FREE_CYC (4),
`ifdef SDR_ARB_TIMEOUT_EN
        .TIMEOUT_CYC  (16),
`endif
        .ID_W         (2)
    ) dut (
        .i_sdr_clk   (clk),
        .i_sdr_rst_n (rst_n),
        .arb         (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n                  = 1'b0;
        arb_if.i_arb_req       = 4'b0000;
        arb_if.i_arb_bus_idle  = 1'b1;
        arb_if.i_sdr_ctrl_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Pulse done for one cycle, check the release, then present next_req.
    task automatic pulse_done(input string tag, input logic [3:0] exp_done, input logic [3:0] next_req);
        arb_if.i_sdr_ctrl_done = 1'b1;
        tick();
        arb_if.i_sdr_ctrl_done = 1'b0;
        chk({tag, "_done"}, 32'(arb_if.o_arb_done), 32'(exp_done));
        chk({tag, "_gnt_off"}, 32'(arb_if.o_arb_gnt), 32'h0);
        chk({tag, "_en_off"}, 32'(arb_if.o_sdr_en), 32'h0);
        arb_if.i_arb_req = next_req;
        tick();
        chk({tag, "_done_clr"}, 32'(arb_if.o_arb_done), 32'h0);
        $display("xfer %s released done=%b", tag, exp_done);
    endtask

    // Counts cycles from the done pulse to the next grant (one already spent
    // inside pulse_done), bounded.
    task automatic wait_grant(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_id);
        int n;
        n = 0;
        while (arb_if.o_arb_gnt == 4'b0000 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_gap"}, 32'(n + 1), 32'd5);
        chk({tag, "_gnt"}, 32'(arb_if.o_arb_gnt), 32'(exp_gnt));
        chk({tag, "_id"}, 32'(arb_if.o_arb_gnt_id), 32'(exp_id));
        $display("xfer %s granted gnt=%b id=%0d gap=%0d", tag, arb_if.o_arb_gnt, arb_if.o_arb_gnt_id, n + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        checks = 0;
        errors = 0;

        // Reset values
        rst_n                  = 1'b0;
        arb_if.i_arb_req       = 4'b0000;
        arb_if.i_arb_bus_idle  = 1'b1;
        arb_if.i_sdr_ctrl_done = 1'b0;
        tick();
        chk("rst_gnt", 32'(arb_if.o_arb_gnt), 32'h0);
        chk("rst_id", 32'(arb_if.o_arb_gnt_id), 32'h0);
        chk("rst_busy", 32'(arb_if.o_arb_busy), 32'h0);
        chk("rst_en", 32'(arb_if.o_sdr_en), 32'h0);
        chk("rst_done", 32'(arb_if.o_arb_done), 32'h0);
        chk("rst_timeout", 32'(arb_if.o_arb_timeout), 32'h0);
        $display("xfer reset outputs gnt=%b busy=%b", arb_if.o_arb_gnt, arb_if.o_arb_busy);

        // 1: single request, 1-cycle latency, enable held until done
        do_reset();
        arb_if.i_arb_req = 4'b0010;
        tick();
        chk("t1_gnt", 32'(arb_if.o_arb_gnt), 32'h2);
        chk("t1_id", 32'(arb_if.o_arb_gnt_id), 32'h1);
        chk("t1_busy", 32'(arb_if.o_arb_busy), 32'h1);
        chk("t1_en", 32'(arb_if.o_sdr_en), 32'h1);
        $display("xfer t1 granted gnt=%b id=%0d", arb_if.o_arb_gnt, arb_if.o_arb_gnt_id);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_en_hold", 32'(arb_if.o_sdr_en), 32'h1);
        end
        pulse_done("t1", 4'b0010, 4'b0000);

        // 2: round robin 1,2,3,1 with wrap skipping slot 0; last is zero-length
        do_reset();
        arb_if.i_arb_req = 4'b1110;
        tick();
        chk("t2a_id", 32'(arb_if.o_arb_gnt_id), 32'h1);
        tick();
        pulse_done("t2a", 4'b0010, 4'b1110);
        wait_grant("t2b", 4'b0100, 2'd2);
        tick();
        pulse_done("t2b", 4'b0100, 4'b1110);
        wait_grant("t2c", 4'b1000, 2'd3);
        tick();
        pulse_done("t2c", 4'b1000, 4'b1110);
        wait_grant("t2d", 4'b0010, 2'd1);
        pulse_done("t2d_zero_len", 4'b0010, 4'b0000);

        // 3: CRH raised during BUSY of id 1 is served before id 2
        do_reset();
        arb_if.i_arb_req = 4'b0110;
        tick();
        chk("t3a_id", 32'(arb_if.o_arb_gnt_id), 32'h1);
        tick();
        arb_if.i_arb_req = 4'b0111;
        tick();
        chk("t3a_hold", 32'(arb_if.o_arb_gnt), 32'h2);
        pulse_done("t3a", 4'b0010, 4'b0101);
        wait_grant("t3b", 4'b0001, 2'd0);
        tick();
        pulse_done("t3b", 4'b0001, 4'b0100);
        wait_grant("t3c", 4'b0100, 2'd2);
        pulse_done("t3c", 4'b0100, 4'b0000);

        // 4: bus not idle blocks arbitration
        do_reset();
        arb_if.i_arb_bus_idle = 1'b0;
        arb_if.i_arb_req      = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_blocked", 32'(arb_if.o_arb_gnt), 32'h0);
        end
        arb_if.i_arb_bus_idle = 1'b1;
        tick();
        chk("t4_gnt", 32'(arb_if.o_arb_gnt), 32'h1);
        chk("t4_id", 32'(arb_if.o_arb_gnt_id), 32'h0);
        $display("xfer t4 granted gnt=%b", arb_if.o_arb_gnt);
        pulse_done("t4", 4'b0001, 4'b0000);

        // 5: asynchronous reset mid-BUSY, then pointer back at 1
        do_reset();
        arb_if.i_arb_req = 4'b0010;
        tick();
        tick();
        chk("t5_pre_gnt", 32'(arb_if.o_arb_gnt), 32'h2);
        rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", 32'(arb_if.o_arb_gnt), 32'h0);
        chk("t5_async_en", 32'(arb_if.o_sdr_en), 32'h0);
        chk("t5_async_busy", 32'(arb_if.o_arb_busy), 32'h0);
        chk("t5_async_done", 32'(arb_if.o_arb_done), 32'h0);
        arb_if.i_arb_req = 4'b1000;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_gnt", 32'(arb_if.o_arb_gnt), 32'h8);
        chk("t5_id", 32'(arb_if.o_arb_gnt_id), 32'h3);
        $display("xfer t5 granted gnt=%b id=%0d", arb_if.o_arb_gnt, arb_if.o_arb_gnt_id);
        pulse_done("t5", 4'b1000, 4'b0000);

        // 6: no done pulse -- watchdog abort or indefinite hold
        do_reset();
        arb_if.i_arb_req = 4'b0100;
        tick();
        chk("t6_gnt", 32'(arb_if.o_arb_gnt), 32'h4);
`ifdef SDR_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) tick();
        chk("t6_pre_abort", 32'(arb_if.o_arb_gnt), 32'h4);
        tick();
        chk("t6_timeout", 32'(arb_if.o_arb_timeout), 32'h1);
        chk("t6_abort_done", 32'(arb_if.o_arb_done), 32'h4);
        chk("t6_abort_gnt", 32'(arb_if.o_arb_gnt), 32'h0);
        tick();
        chk("t6_timeout_clr", 32'(arb_if.o_arb_timeout), 32'h0);
        $display("xfer t6 watchdog abort");
`else
        for (int i = 0; i < 1000; i++) tick();
        chk("t6_hold_gnt", 32'(arb_if.o_arb_gnt), 32'h4);
        chk("t6_hold_en", 32'(arb_if.o_sdr_en), 32'h1);
        chk("t6_no_timeout", 32'(arb_if.o_arb_timeout), 32'h0);
        chk("t6_no_done", 32'(arb_if.o_arb_done), 32'h0);
        $display("xfer t6 grant held after 1000 cycles gnt=%b", arb_if.o_arb_gnt);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sdr_engine_arbiter
